// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: operands and Hack control bits in,
// registered result and flags out, each direction with a valid/ready pair.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic             mul;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             ovf;

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
    input  in_ready, out_valid, out, zr, ng, ovf
  );

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
    output in_ready, out_valid, out, zr, ng, ovf
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle Hack ALU: single-cycle add/and path plus an iterative signed
// shift-add multiplier, with registered result, zr/ng/ovf flags and handshakes.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);
  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic                      ovf_q, ovf_d;
  logic                      zr_q, zr_d;
  logic                      ng_q, ng_d;
  logic                      no_q, no_d;
  logic signed [WIDTH-1:0]   out_q, out_d;
  logic signed [WIDTH-1:0]   mplier_q, mplier_d;
  logic signed [2*WIDTH-1:0] acc_q, acc_d;
  logic signed [2*WIDTH-1:0] mcand_q, mcand_d;

  logic signed [WIDTH-1:0]   xp, yp, sum, r;
  logic signed [2*WIDTH-1:0] term;

  function automatic logic signed [WIDTH-1:0] prep(input logic [WIDTH-1:0] v,
                                                   input logic z, input logic n);
    logic signed [WIDTH-1:0] t;
    t = z ? '0 : v;
    return n ? ~t : t;
  endfunction

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s,
                                   input logic en);
    return en && (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Product fits in WIDTH bits only if the top WIDTH+1 bits are all sign copies.
  function automatic logic prod_ovf(input logic signed [2*WIDTH-1:0] p);
    return p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){p[WIDTH-1]}};
  endfunction

  always_comb begin
    xp          = prep(bus.x, bus.zx, bus.nx);
    yp          = prep(bus.y, bus.zy, bus.ny);
    sum         = xp + yp;
    r           = bus.f ? sum : (xp & yp);
    term        = mplier_q[0] ? mcand_q : '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    no_d        = no_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          no_d = bus.no;
          if (bus.mul) begin
            state_d  = MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{xp[WIDTH-1]}}, xp};
            mplier_d = yp;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_d       = bus.no ? ~r : r;
            ovf_d       = add_ovf(xp, yp, sum, bus.f);
          end
        end
      end
      MUL: begin
        // The multiplier MSB carries negative weight, so the last partial product is subtracted.
        acc_d    = (cnt_q == LAST) ? acc_q - term : acc_q + term;
        mcand_d  = mcand_q <<< 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = DONE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_d       = no_q ? ~acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
          ovf_d       = prod_ovf(acc_d);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    zr_d = (out_d == '0);
    ng_d = out_d[WIDTH-1];
  end

  // Control and architecturally visible result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      zr_q        <= 1'b1;
      ng_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
    end
  end

  // Multiplier datapath registers
  always_ff @(posedge clk) begin
    no_q     <= no_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.ovf       = ovf_q;
endmodule
